exc_sequencer: RTL and testbench

Exception and interrupt sequencer for the 5-stage MIPS pipeline. It detects ALU overflow in E, illegal and syscall instructions in D, and masked external interrupts. It then flushes the pipeline, drains M/W, writes EPC and Cause to coprocessor 0, and redirects fetch to the kernel vector. On `eret` it restores user mode and redirects fetch to EPC. It sits between the controller/hazard logic and coprocessor_0, and is the sole owner of pipeline redirects and flushes for exceptions.

---
 rtl/exc_pkg.sv | 42 ++++
 rtl/exc_sequencer_irq_sync.sv | 27 ++
 rtl/exc_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_exc_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
package exc_pkg;

   // Cause codes reported to coprocessor 0.
   typedef enum logic [2:0] {
      CAUSE_NONE = 3'd0,
      CAUSE_IRQ  = 3'd1,
      CAUSE_OVF  = 3'd2,
      CAUSE_SYS  = 3'd3,
      CAUSE_ILL  = 3'd4
   } cause_t;

   // Sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_ENTER  = 3'd2,
      ST_KERNEL = 3'd3,
      ST_RETURN = 3'd4
   } state_t;

   localparam logic [31:0] DEFAULT_VECTOR_ADDR = 32'h8000_0180;

   // Oldest instruction wins: E-stage overflow, then D-stage illegal, syscall, then interrupt.
   function automatic cause_t selectCause(input logic ovf, input logic ill,
                                          input logic sys, input logic irq);
      cause_t c;
      if (ovf) begin
         c = CAUSE_OVF;
      end else if (ill) begin
         c = CAUSE_ILL;
      end else if (sys) begin
         c = CAUSE_SYS;
      end else if (irq) begin
         c = CAUSE_IRQ;
      end else begin
         c = CAUSE_NONE;
      end
      return c;
   endfunction

endpackage

// File: rtl/exc_sequencer_irq_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt lines.
module irq_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] irqIn,
   output logic [WIDTH-1:0] irqOut
);

   logic [WIDTH-1:0] stage1;
   logic [WIDTH-1:0] stage2;

   // Two register stages to settle metastability before the lines reach the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage1 <= '0;
         stage2 <= '0;
      end else begin
         stage1 <= irqIn;
         stage2 <= stage1;
      end
   end

   assign irqOut = stage2;

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: detects events, flushes and drains the pipeline,
// writes EPC/Cause, redirects fetch to the kernel vector and back on eret.
module exc_sequencer
   import exc_pkg::*;
#(
   parameter logic [31:0] VECTOR_ADDR  = DEFAULT_VECTOR_ADDR,
   parameter int          DRAIN_CYCLES = 2,
   parameter int          IRQ_W        = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IRQ_W-1:0] irq_i,
   input  logic [IRQ_W-1:0] irq_mask_i,
   input  logic             overflow_e,
   input  logic [31:0]      pc_e,
   input  logic             illegal_d,
   input  logic             syscall_d,
   input  logic             eret_d,
   input  logic [31:0]      pc_d,
   input  logic             stall_d,
   input  logic [31:0]      epc_i,
   output logic             flush_f,
   output logic             flush_d,
   output logic             flush_e,
   output logic             busy_o,
   output logic             redirect_o,
   output logic [31:0]      redirect_pc_o,
   output logic             epc_we_o,
   output logic [31:0]      epc_o,
   output logic             cause_we_o,
   output logic [2:0]       cause_o,
   output logic             kernel_mode_o,
   output logic             double_fault_o
);

   localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

   state_t      state;
   state_t      stateNext;
   logic [2:0]  drainCnt;
   logic [31:0] epcLatch;
   cause_t      causeLatch;
   logic        kernelMode;
   logic        doubleFault;

   logic [IRQ_W-1:0] irqSync;
   logic        irqPend;
   logic        ovfEv;
   logic        illEv;
   logic        sysEv;
   logic        irqEv;
   logic        anyEv;
   logic        kernelFault;
   logic        eretGo;
   cause_t      evCause;
   logic [31:0] evEpc;

   logic        flushF;
   logic        flushD;
   logic        flushE;
   logic        busy;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        writeStrobe;

   irq_sync #(.WIDTH(IRQ_W)) uIrqSync (
      .clk    (clk),
      .reset  (reset),
      .irqIn  (irq_i),
      .irqOut (irqSync)
   );

   // Event qualification: D-stage events and interrupts wait for D to be unstalled; overflow never waits.
   always_comb begin
      irqPend     = |(irqSync & irq_mask_i);
      ovfEv       = overflow_e;
      illEv       = ~stall_d & (illegal_d | eret_d);
      sysEv       = ~stall_d & syscall_d;
      irqEv       = ~stall_d & irqPend;
      evCause     = selectCause(ovfEv, illEv, sysEv, irqEv);
      anyEv       = (evCause != CAUSE_NONE);
      evEpc       = ovfEv ? pc_e : pc_d;
      kernelFault = overflow_e | (~stall_d & (illegal_d | syscall_d));
      eretGo      = eret_d & ~stall_d;
   end

   // Next-state selection for the sequencer FSM.
   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE: begin
            if (anyEv) begin
               stateNext = ST_DRAIN;
            end else begin
               stateNext = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (drainCnt <= 3'd1) begin
               stateNext = ST_ENTER;
            end else begin
               stateNext = ST_DRAIN;
            end
         end
         ST_ENTER:  stateNext = ST_KERNEL;
         ST_KERNEL: begin
            if (eretGo) begin
               stateNext = ST_RETURN;
            end else begin
               stateNext = ST_KERNEL;
            end
         end
         ST_RETURN: stateNext = ST_IDLE;
         default:   stateNext = ST_IDLE;
      endcase
   end

   // State, drain counter, EPC/cause latches, mode and sticky double-fault registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         drainCnt    <= 3'd0;
         epcLatch    <= 32'h0;
         causeLatch  <= CAUSE_NONE;
         kernelMode  <= 1'b0;
         doubleFault <= 1'b0;
      end else begin
         state <= stateNext;
         if (state == ST_IDLE && anyEv) begin
            drainCnt   <= DRAIN_INIT;
            epcLatch   <= evEpc;
            causeLatch <= evCause;
         end else if (state == ST_DRAIN) begin
            drainCnt <= drainCnt - 3'd1;
         end
         if (state == ST_ENTER) begin
            kernelMode <= 1'b1;
         end else if (state == ST_RETURN) begin
            kernelMode <= 1'b0;
         end
         if (state == ST_KERNEL && kernelFault) begin
            doubleFault <= 1'b1;
         end
      end
   end

   // Per-state pipeline control: flushes, freeze, CP0 write strobes and fetch redirect.
   always_comb begin
      flushF      = 1'b0;
      flushD      = 1'b0;
      flushE      = 1'b0;
      busy        = 1'b0;
      redirect    = 1'b0;
      redirectPc  = 32'h0;
      writeStrobe = 1'b0;
      case (state)
         ST_IDLE: begin
            if (anyEv) begin
               flushF = 1'b1;
               flushD = 1'b1;
               flushE = 1'b1;
            end else begin
               flushF = 1'b0;
               flushD = 1'b0;
               flushE = 1'b0;
            end
         end
         ST_DRAIN: begin
            busy   = 1'b1;
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
         end
         ST_ENTER: begin
            writeStrobe = 1'b1;
            redirect    = 1'b1;
            redirectPc  = VECTOR_ADDR;
         end
         ST_KERNEL: begin
            if (eretGo) begin
               flushF = 1'b1;
               flushD = 1'b1;
            end else begin
               flushF = 1'b0;
               flushD = 1'b0;
            end
         end
         ST_RETURN: begin
            redirect   = 1'b1;
            redirectPc = epc_i;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign flush_f        = flushF;
   assign flush_d        = flushD;
   assign flush_e        = flushE;
   assign busy_o         = busy;
   assign redirect_o     = redirect;
   assign redirect_pc_o  = redirectPc;
   assign epc_we_o       = writeStrobe;
   assign cause_we_o     = writeStrobe;
   assign epc_o          = epcLatch;
   assign cause_o        = causeLatch;
   assign kernel_mode_o  = kernelMode;
   assign double_fault_o = doubleFault;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed, table-driven bench for exc_sequencer (default parameters).
module tb_exc_sequencer;

   typedef struct packed {
      logic        rst;
      logic [3:0]  irq;
      logic [3:0]  mask;
      logic        ovf;
      logic [31:0] pcE;
      logic        ill;
      logic        sys;
      logic        eret;
      logic [31:0] pcD;
      logic        stall;
      logic [31:0] epcI;
   } in_t;

   typedef struct packed {
      logic [2:0]  fl;     // {flush_f, flush_d, flush_e}
      logic        busy;
      logic        redir;
      logic [31:0] rpc;
      logic        we;     // epc_we_o and cause_we_o
      logic [31:0] epc;
      logic [2:0]  cause;
      logic        kern;
      logic        df;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [3:0]  irq_i;
   logic [3:0]  irq_mask_i;
   logic        overflow_e;
   logic [31:0] pc_e;
   logic        illegal_d;
   logic        syscall_d;
   logic        eret_d;
   logic [31:0] pc_d;
   logic        stall_d;
   logic [31:0] epc_i;
   logic        flush_f;
   logic        flush_d;
   logic        flush_e;
   logic        busy_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        epc_we_o;
   logic [31:0] epc_o;
   logic        cause_we_o;
   logic [2:0]  cause_o;
   logic        kernel_mode_o;
   logic        double_fault_o;

   int nVec = 0;
   int nMis = 0;
   vec_t tbl[$];

   exc_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .irq_i          (irq_i),
      .irq_mask_i     (irq_mask_i),
      .overflow_e     (overflow_e),
      .pc_e           (pc_e),
      .illegal_d      (illegal_d),
      .syscall_d      (syscall_d),
      .eret_d         (eret_d),
      .pc_d           (pc_d),
      .stall_d        (stall_d),
      .epc_i          (epc_i),
      .flush_f        (flush_f),
      .flush_d        (flush_d),
      .flush_e        (flush_e),
      .busy_o         (busy_o),
      .redirect_o     (redirect_o),
      .redirect_pc_o  (redirect_pc_o),
      .epc_we_o       (epc_we_o),
      .epc_o          (epc_o),
      .cause_we_o     (cause_we_o),
      .cause_o        (cause_o),
      .kernel_mode_o  (kernel_mode_o),
      .double_fault_o (double_fault_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void push(input in_t i, input out_t o);
      vec_t v;
      v.i = i;
      v.o = o;
      tbl.push_back(v);
   endfunction

   // One cycle: drive inputs after the falling edge, compare outputs 1 ns later.
   task automatic step(input string name, input in_t i, input out_t o);
      logic [75:0] act;
      logic [75:0] exp;
      @(negedge clk);
      reset      = i.rst;
      irq_i      = i.irq;
      irq_mask_i = i.mask;
      overflow_e = i.ovf;
      pc_e       = i.pcE;
      illegal_d  = i.ill;
      syscall_d  = i.sys;
      eret_d     = i.eret;
      pc_d       = i.pcD;
      stall_d    = i.stall;
      epc_i      = i.epcI;
      #1;
      act = {flush_f, flush_d, flush_e, busy_o, redirect_o, redirect_pc_o,
             epc_we_o, cause_we_o, epc_o, cause_o, kernel_mode_o, double_fault_o};
      exp = {o.fl, o.busy, o.redir, o.rpc, o.we, o.we, o.epc, o.cause, o.kern, o.df};
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got fl=%b busy=%b redir=%b rpc=%h we=%b%b epc=%h cause=%0d kern=%b df=%b, expected fl=%b busy=%b redir=%b rpc=%h we=%b epc=%h cause=%0d kern=%b df=%b",
                  name, act[75:73], busy_o, redirect_o, redirect_pc_o, epc_we_o, cause_we_o,
                  epc_o, cause_o, kernel_mode_o, double_fault_o,
                  o.fl, o.busy, o.redir, o.rpc, o.we, o.epc, o.cause, o.kern, o.df);
      end
   endtask

   initial begin
      in_t  ci;
      out_t co;

      reset = 1'b1; irq_i = 4'b0; irq_mask_i = 4'b0; overflow_e = 1'b0; pc_e = 32'h0;
      illegal_d = 1'b0; syscall_d = 1'b0; eret_d = 1'b0; pc_d = 32'h0; stall_d = 1'b0;
      epc_i = 32'h0;

      // ---------------- vector table ----------------
      ci = '0; co = '0;
      ci.rst = 1'b1; push(ci, co);                          // 0: reset state
      ci.rst = 1'b0;
      repeat (9) push(ci, co);                              // 1..9 idle
      // OVF in cycle 10
      ci.ovf = 1'b1; ci.pcE = 32'h40; ci.pcD = 32'h44; co.fl = 3'b111; push(ci, co);
      ci = '0; co.busy = 1'b1; co.epc = 32'h40; co.cause = 3'd2; push(ci, co); push(ci, co);
      co.fl = 3'b000; co.busy = 1'b0; co.redir = 1'b1; co.rpc = 32'h8000_0180; co.we = 1'b1;
      push(ci, co);                                         // 13 ENTER
      co.redir = 1'b0; co.rpc = 32'h0; co.we = 1'b0; co.kern = 1'b1; push(ci, co); // 14
      ci.ill = 1'b1; ci.pcD = 32'h48; push(ci, co);         // illegal in KERNEL: no redirect
      ci = '0; co.df = 1'b1; push(ci, co);
      ci.eret = 1'b1; co.fl = 3'b110; push(ci, co);         // eret in KERNEL
      ci.eret = 1'b0; ci.epcI = 32'h104; co.fl = 3'b000; co.redir = 1'b1; co.rpc = 32'h104;
      push(ci, co);                                         // RETURN
      ci.epcI = 32'h0; co.redir = 1'b0; co.rpc = 32'h0; co.kern = 1'b0; push(ci, co);
      // simultaneous OVF and SYS
      ci.ovf = 1'b1; ci.pcE = 32'h200; ci.sys = 1'b1; ci.pcD = 32'h204; co.fl = 3'b111;
      push(ci, co);
      ci = '0; co.busy = 1'b1; co.epc = 32'h200; co.cause = 3'd2; push(ci, co); push(ci, co);
      co.fl = 3'b000; co.busy = 1'b0; co.redir = 1'b1; co.rpc = 32'h8000_0180; co.we = 1'b1;
      push(ci, co);
      co.redir = 1'b0; co.rpc = 32'h0; co.we = 1'b0; co.kern = 1'b1; push(ci, co);
      push(ci, co);                                         // exactly one ENTER
      ci.eret = 1'b1; ci.stall = 1'b1; push(ci, co);        // stalled eret ignored
      ci.stall = 1'b0; co.fl = 3'b110; push(ci, co);
      ci.eret = 1'b0; ci.epcI = 32'h204; co.fl = 3'b000; co.redir = 1'b1; co.rpc = 32'h204;
      push(ci, co);
      ci.epcI = 32'h0; co.redir = 1'b0; co.rpc = 32'h0; co.kern = 1'b0; push(ci, co);
      // SYS then reset mid-DRAIN
      ci.sys = 1'b1; ci.pcD = 32'h300; co.fl = 3'b111; push(ci, co);
      ci = '0; co.busy = 1'b1; co.epc = 32'h300; co.cause = 3'd3; push(ci, co);
      ci.rst = 1'b1; co = '0; push(ci, co);
      ci.rst = 1'b0; push(ci, co);                          // no strobe after reset
      ci.sys = 1'b1; ci.stall = 1'b1; push(ci, co);         // stalled syscall ignored
      ci = '0; ci.eret = 1'b1; ci.pcD = 32'h400; co.fl = 3'b111; push(ci, co); // eret in IDLE
      ci = '0; co.busy = 1'b1; co.epc = 32'h400; co.cause = 3'd4; push(ci, co); push(ci, co);
      co.fl = 3'b000; co.busy = 1'b0; co.redir = 1'b1; co.rpc = 32'h8000_0180; co.we = 1'b1;
      push(ci, co);
      co.redir = 1'b0; co.rpc = 32'h0; co.we = 1'b0; co.kern = 1'b1; push(ci, co);
      ci.eret = 1'b1; co.fl = 3'b110; push(ci, co);
      ci.eret = 1'b0; ci.epcI = 32'h500; co.fl = 3'b000; co.redir = 1'b1; co.rpc = 32'h500;
      push(ci, co);
      ci.epcI = 32'h0; co.redir = 1'b0; co.rpc = 32'h0; co.kern = 1'b0; push(ci, co);
      // OVF accepted while D is stalled
      ci.ovf = 1'b1; ci.stall = 1'b1; ci.pcE = 32'h600; ci.pcD = 32'h604; co.fl = 3'b111;
      push(ci, co);
      ci = '0; co.busy = 1'b1; co.epc = 32'h600; co.cause = 3'd2; push(ci, co);

      for (int k = 0; k < tbl.size(); k++) begin
         step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);
      end

      // ---------------- IRQ: masked, then enabled ----------------
      ci = '0; co = '0;
      ci.rst = 1'b1; step("irq_reset", ci, co);
      ci.rst = 1'b0; ci.irq = 4'b0010; ci.mask = 4'b0000; ci.pcD = 32'h100;
      for (int k = 0; k < 4; k++) begin
         step($sformatf("irq_masked%0d", k), ci, co);
      end
      ci.mask = 4'b0010; co.fl = 3'b111; step("irq_accept", ci, co);
      co.busy = 1'b1; co.epc = 32'h100; co.cause = 3'd1;
      step("irq_drain1", ci, co);
      step("irq_drain2", ci, co);
      co.fl = 3'b000; co.busy = 1'b0; co.redir = 1'b1; co.rpc = 32'h8000_0180; co.we = 1'b1;
      step("irq_enter", ci, co);
      co.redir = 1'b0; co.rpc = 32'h0; co.we = 1'b0; co.kern = 1'b1;
      step("irq_kernel_ignored", ci, co);

      // ---------------- IRQ synchronizer latency ----------------
      ci = '0; co = '0;
      ci.rst = 1'b1; step("lat_reset", ci, co);
      ci.rst = 1'b0; ci.irq = 4'b0010; ci.mask = 4'b0010; ci.pcD = 32'h180;
      step("lat_edge0", ci, co);
      step("lat_edge1", ci, co);
      co.fl = 3'b111; step("lat_pend", ci, co);
      ci.irq = 4'b0000; co.busy = 1'b1; co.epc = 32'h180; co.cause = 3'd1;
      step("lat_drain", ci, co);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
